// File: rtl/arith_issue_queue_if.sv
// Dispatch, wakeup (CDB), issue and status bundle for the arithmetic issue queue.
// master = dispatcher/pipeline side, slave = the queue itself.
interface arith_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_opcode;
  logic [TAG_W-1:0] disp_rob;
  logic [TAG_W-1:0] disp_dest;
  logic [TAG_W-1:0] disp_flag;
  logic             disp_a_rdy;
  logic             disp_b_rdy;
  logic             disp_f_rdy;
  logic [TAG_W-1:0] disp_a_tag;
  logic [TAG_W-1:0] disp_b_tag;
  logic [TAG_W-1:0] disp_f_tag;
  logic [7:0]       disp_a_val;
  logic [7:0]       disp_b_val;
  logic [7:0]       disp_f_val;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [7:0]       cdb_val;
  logic             issue_valid;
  logic [3:0]       issue_opcode;
  logic [TAG_W-1:0] issue_rob;
  logic [TAG_W-1:0] issue_dest;
  logic [TAG_W-1:0] issue_flag;
  logic [7:0]       issue_a;
  logic [7:0]       issue_b;
  logic [7:0]       issue_f;
  logic [CW-1:0]    count;

  modport master (
    output flush, disp_valid, disp_opcode, disp_rob, disp_dest, disp_flag,
           disp_a_rdy, disp_b_rdy, disp_f_rdy, disp_a_tag, disp_b_tag, disp_f_tag,
           disp_a_val, disp_b_val, disp_f_val, cdb_valid, cdb_tag, cdb_val,
    input  disp_ready, issue_valid, issue_opcode, issue_rob, issue_dest, issue_flag,
           issue_a, issue_b, issue_f, count
  );

  modport slave (
    input  flush, disp_valid, disp_opcode, disp_rob, disp_dest, disp_flag,
           disp_a_rdy, disp_b_rdy, disp_f_rdy, disp_a_tag, disp_b_tag, disp_f_tag,
           disp_a_val, disp_b_val, disp_f_val, cdb_valid, cdb_tag, cdb_val,
    output disp_ready, issue_valid, issue_opcode, issue_rob, issue_dest, issue_flag,
           issue_a, issue_b, issue_f, count
  );
endinterface

// File: rtl/arith_issue_queue.sv
// Age-ordered compacting reservation station for ALU micro-ops: captures CDB
// results, issues the oldest fully-ready entry per cycle through registered outputs.
module arith_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input logic               i_clk,
  input logic               i_rst,
  arith_issue_queue_if.slave io_bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [7:0]       val;
  } opnd_t;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [TAG_W-1:0] rob;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] flag;
    opnd_t            a;
    opnd_t            b;
    opnd_t            f;
  } entry_t;

  entry_t           r_slot [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_iss_valid;
  logic [3:0]       r_iss_opcode;
  logic [TAG_W-1:0] r_iss_rob;
  logic [TAG_W-1:0] r_iss_dest;
  logic [TAG_W-1:0] r_iss_flag;
  logic [7:0]       r_iss_a;
  logic [7:0]       r_iss_b;
  logic [7:0]       r_iss_f;

  entry_t           w_shift [DEPTH];
  entry_t           w_next  [DEPTH];
  entry_t           w_new;
  entry_t           w_sel_ent;
  logic             w_sel_valid;
  logic [IW-1:0]    w_sel_idx;
  logic             w_accept;
  logic [CW-1:0]    w_cnt_rem;
  logic [CW-1:0]    w_cnt_next;

  function automatic opnd_t wake(input opnd_t o, input logic v,
                                 input logic [TAG_W-1:0] t, input logic [7:0] d);
    opnd_t r;
    r = o;
    if (v && !o.rdy && (o.tag == t)) begin
      r.rdy = 1'b1;
      r.val = d;
    end
    return r;
  endfunction

  assign w_accept = io_bus.disp_valid && (r_count < CW'(DEPTH));

  // Select looks at stored readiness only; operands woken this cycle wait a cycle.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CW'(i) < r_count) && r_slot[i].a.rdy && r_slot[i].b.rdy && r_slot[i].f.rdy) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IW'(i);
      end
    end
  end

  assign w_sel_ent = r_slot[w_sel_idx];

  always_comb begin
    w_new.opcode = io_bus.disp_opcode;
    w_new.rob    = io_bus.disp_rob;
    w_new.dest   = io_bus.disp_dest;
    w_new.flag   = io_bus.disp_flag;
    w_new.a      = wake('{rdy: io_bus.disp_a_rdy, tag: io_bus.disp_a_tag, val: io_bus.disp_a_val},
                        io_bus.cdb_valid, io_bus.cdb_tag, io_bus.cdb_val);
    w_new.b      = wake('{rdy: io_bus.disp_b_rdy, tag: io_bus.disp_b_tag, val: io_bus.disp_b_val},
                        io_bus.cdb_valid, io_bus.cdb_tag, io_bus.cdb_val);
    w_new.f      = wake('{rdy: io_bus.disp_f_rdy, tag: io_bus.disp_f_tag, val: io_bus.disp_f_val},
                        io_bus.cdb_valid, io_bus.cdb_tag, io_bus.cdb_val);
  end

  // Remove the issued slot, wake the compacted contents, then append behind them.
  always_comb begin
    w_cnt_rem  = r_count - CW'(w_sel_valid);
    w_cnt_next = w_cnt_rem + CW'(w_accept);
    for (int i = 0; i < DEPTH; i++) begin
      w_shift[i] = r_slot[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (w_sel_valid && (IW'(i) >= w_sel_idx)) begin
        w_shift[i] = r_slot[i + 1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i]   = w_shift[i];
      w_next[i].a = wake(w_shift[i].a, io_bus.cdb_valid, io_bus.cdb_tag, io_bus.cdb_val);
      w_next[i].b = wake(w_shift[i].b, io_bus.cdb_valid, io_bus.cdb_tag, io_bus.cdb_val);
      w_next[i].f = wake(w_shift[i].f, io_bus.cdb_valid, io_bus.cdb_tag, io_bus.cdb_val);
      if (w_accept && (CW'(i) == w_cnt_rem)) begin
        w_next[i] = w_new;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= '0;
      end
      r_count      <= '0;
      r_iss_valid  <= 1'b0;
      r_iss_opcode <= '0;
      r_iss_rob    <= '0;
      r_iss_dest   <= '0;
      r_iss_flag   <= '0;
      r_iss_a      <= '0;
      r_iss_b      <= '0;
      r_iss_f      <= '0;
    end else if (io_bus.flush) begin
      r_count     <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= w_next[i];
      end
      r_count     <= w_cnt_next;
      r_iss_valid <= w_sel_valid;
      if (w_sel_valid) begin
        r_iss_opcode <= w_sel_ent.opcode;
        r_iss_rob    <= w_sel_ent.rob;
        r_iss_dest   <= w_sel_ent.dest;
        r_iss_flag   <= w_sel_ent.flag;
        r_iss_a      <= w_sel_ent.a.val;
        r_iss_b      <= w_sel_ent.b.val;
        r_iss_f      <= w_sel_ent.f.val;
      end
    end
  end

  assign io_bus.disp_ready   = (r_count < CW'(DEPTH));
  assign io_bus.count        = r_count;
  assign io_bus.issue_valid  = r_iss_valid;
  assign io_bus.issue_opcode = r_iss_opcode;
  assign io_bus.issue_rob    = r_iss_rob;
  assign io_bus.issue_dest   = r_iss_dest;
  assign io_bus.issue_flag   = r_iss_flag;
  assign io_bus.issue_a      = r_iss_a;
  assign io_bus.issue_b      = r_iss_b;
  assign io_bus.issue_f      = r_iss_f;
endmodule

// File: tb/tb_arith_issue_queue.sv
// Self-checking bench for arith_issue_queue: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_arith_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  arith_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
  arith_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  typedef struct {
    logic [3:0] op;
    logic [4:0] rob, dest, flag;
    bit         ar, br, fr;
    logic [4:0] at, bt, ft;
    logic [7:0] av, bv, fv;
  } m_ent_t;

  m_ent_t     mq[$];
  bit         e_valid;
  logic [3:0] e_op;
  logic [4:0] e_rob, e_dest, e_flag;
  logic [7:0] e_a, e_b, e_f;

  task automatic idle();
    bus.flush = 0; bus.disp_valid = 0; bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_val = 0;
  endtask

  task automatic drive_disp(input logic [3:0] op, input logic [4:0] rob,
                            input bit ar, input logic [4:0] at, input logic [7:0] av,
                            input bit br, input logic [4:0] bt, input logic [7:0] bv,
                            input bit fr, input logic [4:0] ft, input logic [7:0] fv);
    bus.disp_valid = 1; bus.disp_opcode = op; bus.disp_rob = rob;
    bus.disp_dest = rob ^ 5'h15; bus.disp_flag = rob ^ 5'h0a;
    bus.disp_a_rdy = ar; bus.disp_a_tag = at; bus.disp_a_val = av;
    bus.disp_b_rdy = br; bus.disp_b_tag = bt; bus.disp_b_val = bv;
    bus.disp_f_rdy = fr; bus.disp_f_tag = ft; bus.disp_f_val = fv;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [7:0] v);
    bus.cdb_valid = 1; bus.cdb_tag = t; bus.cdb_val = v;
  endtask

  // Model: oldest ready entry leaves, survivors see the broadcast, then the newcomer joins.
  task automatic tick();
    m_ent_t e;
    int     sel;
    bit     acc;
    acc = bus.disp_valid && (mq.size() < DEPTH);
    if (bus.flush) begin
      mq.delete();
      e_valid = 0;
    end else begin
      sel = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].ar && mq[i].br && mq[i].fr) sel = i;
      if (sel >= 0) begin
        e_valid = 1; e_op = mq[sel].op; e_rob = mq[sel].rob; e_dest = mq[sel].dest;
        e_flag = mq[sel].flag; e_a = mq[sel].av; e_b = mq[sel].bv; e_f = mq[sel].fv;
        mq.delete(sel);
      end else e_valid = 0;
      if (bus.cdb_valid) foreach (mq[i]) begin
        if (!mq[i].ar && mq[i].at == bus.cdb_tag) begin mq[i].ar = 1; mq[i].av = bus.cdb_val; end
        if (!mq[i].br && mq[i].bt == bus.cdb_tag) begin mq[i].br = 1; mq[i].bv = bus.cdb_val; end
        if (!mq[i].fr && mq[i].ft == bus.cdb_tag) begin mq[i].fr = 1; mq[i].fv = bus.cdb_val; end
      end
      if (acc) begin
        e.op = bus.disp_opcode; e.rob = bus.disp_rob; e.dest = bus.disp_dest; e.flag = bus.disp_flag;
        e.ar = bus.disp_a_rdy; e.at = bus.disp_a_tag; e.av = bus.disp_a_val;
        e.br = bus.disp_b_rdy; e.bt = bus.disp_b_tag; e.bv = bus.disp_b_val;
        e.fr = bus.disp_f_rdy; e.ft = bus.disp_f_tag; e.fv = bus.disp_f_val;
        if (bus.cdb_valid) begin
          if (!e.ar && e.at == bus.cdb_tag) begin e.ar = 1; e.av = bus.cdb_val; end
          if (!e.br && e.bt == bus.cdb_tag) begin e.br = 1; e.bv = bus.cdb_val; end
          if (!e.fr && e.ft == bus.cdb_tag) begin e.fr = 1; e.fv = bus.cdb_val; end
        end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    e_valid = 0; e_op = 0; e_rob = 0; e_dest = 0; e_flag = 0; e_a = 0; e_b = 0; e_f = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_checks++;
    if (bus.disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.disp_ready); end
    n_checks++;
    if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid got=%b exp=0", bus.issue_valid); end
    n_checks++;
    if ({bus.issue_opcode, bus.issue_rob, bus.issue_dest, bus.issue_flag, bus.issue_a, bus.issue_b, bus.issue_f} !== '0) begin
      n_fail++; $display("FAIL reset_issue_data got=%h/%h/%h/%h exp=0", bus.issue_opcode, bus.issue_rob, bus.issue_a, bus.issue_f);
    end
  endtask

  task automatic test_ready_dispatch();
    drive_disp(4'h2, 5'd7, 1, 0, 8'h10, 1, 0, 8'h05, 1, 0, 8'h00);
    tick();
    idle();
    n_checks++;
    if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL ready_early got=%b exp=0", bus.issue_valid); end
    tick();
    n_checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_opcode !== 4'h2 || bus.issue_rob !== 5'd7) begin
      n_fail++; $display("FAIL ready_issue got v=%b op=%h rob=%0d exp v=1 op=2 rob=7", bus.issue_valid, bus.issue_opcode, bus.issue_rob);
    end
    n_checks++;
    if (bus.issue_a !== 8'h10 || bus.issue_b !== 8'h05 || bus.issue_f !== 8'h00) begin
      n_fail++; $display("FAIL ready_operands got a=%h b=%h f=%h exp a=10 b=05 f=00", bus.issue_a, bus.issue_b, bus.issue_f);
    end
    n_checks++;
    if (bus.issue_dest !== (5'd7 ^ 5'h15) || bus.issue_flag !== (5'd7 ^ 5'h0a)) begin
      n_fail++; $display("FAIL ready_dest got dest=%0d flag=%0d exp dest=%0d flag=%0d", bus.issue_dest, bus.issue_flag, 5'd7 ^ 5'h15, 5'd7 ^ 5'h0a);
    end
    tick();
    n_checks++;
    if (bus.issue_valid !== 1'b0 || bus.issue_rob !== 5'd7) begin
      n_fail++; $display("FAIL ready_pulse got v=%b rob=%0d exp v=0 rob=7", bus.issue_valid, bus.issue_rob);
    end
  endtask

  task automatic test_wakeup_order();
    drive_disp(4'h3, 5'd1, 0, 5'd9, 8'h00, 1, 0, 8'h22, 1, 0, 8'h01);
    tick();
    drive_disp(4'h4, 5'd2, 1, 0, 8'h33, 1, 0, 8'h44, 1, 0, 8'h02);
    tick();
    idle();
    tick();
    n_checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_rob !== 5'd2) begin
      n_fail++; $display("FAIL order_young_first got v=%b rob=%0d exp v=1 rob=2", bus.issue_valid, bus.issue_rob);
    end
    cdb(5'd9, 8'hAB);
    tick();
    idle();
    n_checks++;
    if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL order_wake_early got=%b exp=0", bus.issue_valid); end
    tick();
    n_checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_rob !== 5'd1 || bus.issue_a !== 8'hAB || bus.issue_b !== 8'h22) begin
      n_fail++; $display("FAIL order_woken got v=%b rob=%0d a=%h b=%h exp v=1 rob=1 a=ab b=22", bus.issue_valid, bus.issue_rob, bus.issue_a, bus.issue_b);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    drive_disp(4'h5, 5'd3, 0, 5'd3, 8'h00, 1, 0, 8'h66, 1, 0, 8'h80);
    cdb(5'd3, 8'h55);
    tick();
    idle();
    tick();
    n_checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_rob !== 5'd3 || bus.issue_a !== 8'h55) begin
      n_fail++; $display("FAIL same_cycle got v=%b rob=%0d a=%h exp v=1 rob=3 a=55", bus.issue_valid, bus.issue_rob, bus.issue_a);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive_disp(4'h6, 5'(10 + i), 0, 5'(20 + i), 8'h00, 1, 0, 8'(i), 1, 0, 8'h00);
      tick();
    end
    idle();
    n_checks++;
    if (bus.count !== CW'(DEPTH) || bus.disp_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_state got count=%0d ready=%b exp count=%0d ready=0", bus.count, bus.disp_ready, DEPTH);
    end
    drive_disp(4'h7, 5'd14, 1, 0, 8'h01, 1, 0, 8'h02, 1, 0, 8'h03);
    tick();
    idle();
    n_checks++;
    if (bus.count !== CW'(DEPTH) || bus.issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_ignored got count=%0d v=%b exp count=%0d v=0", bus.count, bus.issue_valid, DEPTH);
    end
    cdb(5'd20, 8'hA0);
    tick();
    idle();
    cdb(5'd21, 8'hA1);
    drive_disp(4'h8, 5'd15, 1, 0, 8'hF1, 1, 0, 8'hF2, 1, 0, 8'hF3);
    tick();
    n_checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_rob !== 5'd10 || bus.issue_a !== 8'hA0 || bus.count !== CW'(DEPTH - 1)) begin
      n_fail++; $display("FAIL full_first_issue got v=%b rob=%0d a=%h count=%0d exp v=1 rob=10 a=a0 count=%0d", bus.issue_valid, bus.issue_rob, bus.issue_a, bus.count, DEPTH - 1);
    end
    idle();
    drive_disp(4'h8, 5'd15, 1, 0, 8'hF1, 1, 0, 8'hF2, 1, 0, 8'hF3);
    tick();
    idle();
    n_checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_rob !== 5'd11 || bus.count !== CW'(DEPTH - 1)) begin
      n_fail++; $display("FAIL full_issue_and_dispatch got v=%b rob=%0d count=%0d exp v=1 rob=11 count=%0d", bus.issue_valid, bus.issue_rob, bus.count, DEPTH - 1);
    end
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 1) cdb(5'd23, 8'hA3);
      if (c == 2) cdb(5'd22, 8'hA2);
      tick();
      n_checks++;
      if (bus.issue_valid !== e_valid || bus.issue_rob !== e_rob || bus.issue_a !== e_a || bus.count !== CW'(mq.size())) begin
        n_fail++; $display("FAIL full_drain c=%0d got v=%b rob=%0d a=%h count=%0d exp v=%b rob=%0d a=%h count=%0d",
                           c, bus.issue_valid, bus.issue_rob, bus.issue_a, bus.count, e_valid, e_rob, e_a, mq.size());
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++) begin
      drive_disp(4'h9, 5'(16 + i), 1, 0, 8'h00, 0, 5'(24 + i), 8'h00, 1, 0, 8'h00);
      tick();
    end
    idle();
    bus.flush = 1;
    drive_disp(4'hA, 5'd31, 1, 0, 8'h01, 1, 0, 8'h02, 1, 0, 8'h03);
    tick();
    idle();
    n_checks++;
    if (bus.count !== '0 || bus.issue_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_clear got count=%0d v=%b ready=%b exp count=0 v=0 ready=1", bus.count, bus.issue_valid, bus.disp_ready);
    end
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c < DEPTH) cdb(5'(24 + c), 8'hB0);
      tick();
      n_checks++;
      if (bus.issue_valid !== 1'b0 || bus.count !== '0) begin
        n_fail++; $display("FAIL flush_no_issue c=%0d got v=%b rob=%0d count=%0d exp v=0 count=0", c, bus.issue_valid, bus.issue_rob, bus.count);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      n_checks++;
      if (bus.disp_ready !== (mq.size() < DEPTH) || bus.count !== CW'(mq.size())) begin
        n_fail++; $display("FAIL rand_status c=%0d got ready=%b count=%0d exp count=%0d", c, bus.disp_ready, bus.count, mq.size());
      end
      if ($urandom_range(99) < 60)
        drive_disp(4'($urandom), 5'($urandom),
                   $urandom_range(9) < 7, 5'($urandom_range(7)), 8'($urandom),
                   $urandom_range(9) < 7, 5'($urandom_range(7)), 8'($urandom),
                   $urandom_range(9) < 7, 5'($urandom_range(7)), 8'($urandom));
      if ($urandom_range(1) == 1) cdb(5'($urandom_range(7)), 8'($urandom));
      if ($urandom_range(99) < 3) bus.flush = 1;
      tick();
      n_checks++;
      if (bus.issue_valid !== e_valid || bus.issue_opcode !== e_op || bus.issue_rob !== e_rob ||
          bus.issue_dest !== e_dest || bus.issue_flag !== e_flag || bus.issue_a !== e_a ||
          bus.issue_b !== e_b || bus.issue_f !== e_f) begin
        n_fail++; $display("FAIL rand_issue c=%0d got v=%b op=%h rob=%0d a=%h b=%h f=%h exp v=%b op=%h rob=%0d a=%h b=%h f=%h",
                           c, bus.issue_valid, bus.issue_opcode, bus.issue_rob, bus.issue_a, bus.issue_b, bus.issue_f,
                           e_valid, e_op, e_rob, e_a, e_b, e_f);
      end
    end
    idle();
    bus.flush = 1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive_disp(4'hB, 5'(4 + i), 0, 5'(12 + i), 8'h00, 1, 0, 8'h00, 1, 0, 8'h00);
      tick();
    end
    idle();
    n_checks++;
    if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL rstmid_fill got=%0d exp=3", bus.count); end
    #2;
    rst = 1;
    model_reset();
    #1;
    n_checks++;
    if (bus.count !== '0 || bus.disp_ready !== 1'b1 || bus.issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got count=%0d ready=%b v=%b exp count=0 ready=1 v=0", bus.count, bus.disp_ready, bus.issue_valid);
    end
    #2;
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c < 3) cdb(5'(12 + c), 8'hC0);
      tick();
      n_checks++;
      if (bus.issue_valid !== 1'b0 || bus.count !== '0) begin
        n_fail++; $display("FAIL rstmid_no_issue c=%0d got v=%b count=%0d exp v=0 count=0", c, bus.issue_valid, bus.count);
      end
    end
  endtask

  initial begin
    idle();
    drive_disp(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    bus.disp_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    test_reset();
    test_ready_dispatch();
    test_wakeup_order();
    test_same_cycle();
    test_full();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arith_issue_queue.md
# arith_issue_queue

Reservation station and issue scheduler for the arithmetic pipeline in the out-of-order 6502 core. It buffers up to DEPTH dispatched ALU micro-ops and captures operand and flag values from the common data bus (CDB) as they are produced. Each cycle it issues the oldest fully-ready entry to the arithmetic pipeline through registered outputs. The pipeline never stalls, so one issue per cycle is always accepted.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_W, 5, physical register / ROB tag width

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all entries (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  high when count < DEPTH
- disp_opcode  in  4  ALU opcode
- disp_rob  in  TAG_W  ROB entry
- disp_dest  in  TAG_W  destination physical register
- disp_flag  in  TAG_W  destination flag register
- disp_a_rdy / disp_b_rdy / disp_f_rdy  in  1 each  operand already available
- disp_a_tag / disp_b_tag / disp_f_tag  in  TAG_W each  producer tag when not ready
- disp_a_val / disp_b_val / disp_f_val  in  8 each  value when ready
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  broadcast tag, matched against A, B and F tags
- cdb_val  in  8  broadcast value
- issue_valid  out  1  drives pipeline instr_valid
- issue_opcode  out  4
- issue_rob, issue_dest, issue_flag  out  TAG_W each
- issue_a, issue_b, issue_f  out  8 each  operand A, operand B and flags values
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage is an age-ordered compacting queue.
  - Slot 0 holds the oldest entry. Slots 0..count-1 are valid.
  - Each slot holds opcode, rob, dest, flag and three operand fields {rdy, tag, val}.
- Dispatch is accepted when disp_valid && disp_ready.
  - Tag and value fields are ignored when the corresponding rdy bit is set.
- Wakeup: when cdb_valid is high, every stored operand with rdy=0 and tag==cdb_tag gets rdy=1 and val=cdb_val.
  - The incoming dispatch operands get the same compare in the same cycle, so a producer broadcasting in the dispatch cycle is captured.
- Select: the lowest-index valid slot whose A, B and F are all rdy, using stored state only.
  - An operand woken this cycle is not visible to select until the next cycle.
- Issue: the selected slot's fields are registered into the issue_* outputs with issue_valid=1, and the slot is removed.
  - Younger slots shift down by one.
  - With no candidate, issue_valid=0 and the other issue_* outputs hold their previous values.
- Simultaneous issue and dispatch:
  - Removal happens first, then the new entry is appended at slot count-1.
  - count is unchanged.
  - disp_ready is computed from count before removal; no same-cycle credit.
- Simultaneous wakeup and issue/shift: wakeup is applied to the shifted slot contents. No broadcast is lost.
- flush:
  - All slots are invalidated and count becomes 0 at the edge.
  - A dispatch in the same cycle is dropped.
  - issue_valid=0 in the following cycle.
  - flush takes priority over dispatch, wakeup and issue.
- Entries never exceed DEPTH; count wraps nowhere.

## Timing
- Reset (async assert, sync release):
  - count=0, all slots invalid, issue_valid=0.
  - All issue_* data outputs are 0; disp_ready=1.
- disp_ready and count are registered-state combinational outputs, with no dependence on disp_valid.
- Dispatch with all rdy=1 accepted at edge k: issue_valid=1 in the cycle after edge k+1. Minimum latency is 2 edges.
- Operand completed by CDB at edge k: dependent entry issues after edge k+1 at the earliest.
- issue_valid is a one-cycle pulse per issued entry; back-to-back issue is possible every cycle.
- Issue outputs feed the pipeline registers directly; the pipeline result appears one edge later.

## Test plan
- Reset mid-operation:
  - Stimulus: fill 3 entries, then assert rst asynchronously between edges.
  - Required: count=0, disp_ready=1, issue_valid=0 immediately; no issue after release.
- Ready dispatch:
  - Stimulus: dispatch opcode 4'h2, rob 5'd7, a=8'h10, b=8'h05, f=8'h00, all rdy.
  - Required: issue_valid=1 with those values exactly 2 edges after acceptance.
- Wakeup ordering:
  - Stimulus: dispatch X waiting on tag 9, then dispatch ready entry Y.
  - Required: Y issues first.
  - Stimulus: then CDB tag 9 val 8'hAB.
  - Required: X issues next edge+1 with issue_a=8'hAB.
- Same-cycle capture:
  - Stimulus: dispatch with a_tag=3, a_rdy=0 while cdb_valid, cdb_tag=3, cdb_val=8'h55.
  - Required: entry issues with issue_a=8'h55 with no further broadcast.
- Full and simultaneous:
  - Stimulus: fill DEPTH entries.
  - Required: disp_ready=0 and a further disp_valid is ignored.
  - Stimulus: issue one entry while dispatching in the same cycle the queue reopens.
  - Required: count stays consistent and age order is preserved.
- Flush:
  - Stimulus: assert flush with 4 entries and a concurrent dispatch.
  - Required: count=0 next cycle, no issue_valid afterwards, and the dispatched op is never issued.
